// File: rtl/rd_adr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rd_seq_pkg
//  Purpose  : Shared types and helpers for the read-address sequencer.
//             - seq_state_t : burst FSM state encoding (IDLE / SLOT / DONE)
//             - ch_width()  : clog2-based channel-index width, never below 1
//  Revision : 1.0  initial release
// ============================================================================
package rd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLOT = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // A single-channel build still needs a 1-bit index port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_adr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : rd_adr_sequencer_if
//  Purpose  : Strobe / read-pulse bundle between the frame-timing logic,
//             the sequencer and the per-channel buffer RAMs.
//  Signals  : strob[N_CH]    request strobes into the sequencer
//             rd[N_CH]       one-hot read pulse
//             rd_adr[ADR_W]  current word address
//             adr_valid      burst in progress
//             ch_idx[CH_W]   granted channel
//             busy           grant through done, inclusive
//             done[N_CH]     burst-complete pulse
//             overrun[N_CH]  dropped-strobe pulse
//  Modports : master = sequencer side, slave = consumer/stimulus side
//  Revision : 1.0  initial release
// ============================================================================
interface rd_adr_sequencer_if #(
    parameter int N_CH  = 5,
    parameter int ADR_W = 5
);
    import rd_seq_pkg::*;

    localparam int CH_W = ch_width(N_CH);

    logic [N_CH-1:0]  strob;
    logic [N_CH-1:0]  rd;
    logic [ADR_W-1:0] rd_adr;
    logic             adr_valid;
    logic [CH_W-1:0]  ch_idx;
    logic             busy;
    logic [N_CH-1:0]  done;
    logic [N_CH-1:0]  overrun;

    modport master (
        input  strob,
        output rd, rd_adr, adr_valid, ch_idx, busy, done, overrun
    );

    modport slave (
        output strob,
        input  rd, rd_adr, adr_valid, ch_idx, busy, done, overrun
    );

endinterface
`default_nettype wire

// File: rtl/rd_adr_sequencer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rd_seq_arbiter
//  Purpose  : Combinational winner select over the pending vector.
//             ARB_RR=0 : lowest pending index wins.
//             ARB_RR=1 : first pending index at or after ptr, wrapping.
//  Ports    : pending[N_CH] in  requests
//             ptr[CH_W]     in  round-robin start index
//             grant[CH_W]   out winning index (0 when none)
//             any           out at least one request pending
//  Revision : 1.0  initial release
// ============================================================================
module rd_seq_arbiter
    import rd_seq_pkg::*;
#(
    parameter int N_CH   = 5,
    parameter int ARB_RR = 0
) (
    input  logic [N_CH-1:0]            pending,
    input  logic [ch_width(N_CH)-1:0]  ptr,
    output logic [ch_width(N_CH)-1:0]  grant,
    output logic                       any
);
    localparam int CH_W = ch_width(N_CH);

    // Two passes give the modulo wrap without a rotator: first the indices
    // at or above the pointer, then everything from 0 upwards.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            if ((ARB_RR != 0) && !any && pending[j] && (j >= int'(ptr))) begin
                any   = 1'b1;
                grant = CH_W'(j);
            end
        end
        for (int j = 0; j < N_CH; j++) begin
            if (!any && pending[j]) begin
                any   = 1'b1;
                grant = CH_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rd_adr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rd_adr_sequencer
//  Purpose  : Per-channel strobe capture plus a burst FSM that walks
//             N_WORDS addresses for one granted channel, each word in a
//             SLOT_LEN-cycle slot with rd high for slot cycles
//             [RD_ON, RD_OFF).
//  Ports    : clk  system clock
//             rst  synchronous active-high reset
//             bus  rd_adr_sequencer_if.master (strob in; rd, rd_adr,
//                  adr_valid, ch_idx, busy, done, overrun out)
//  Revision : 1.0  initial release
// ============================================================================
module rd_adr_sequencer
    import rd_seq_pkg::*;
#(
    parameter int N_CH     = 5,
    parameter int N_WORDS  = 18,
    parameter int ADR_W    = 5,
    parameter int SLOT_LEN = 64,
    parameter int RD_ON    = 40,
    parameter int RD_OFF   = 44,
    parameter int ARB_RR   = 0
) (
    input  logic             clk,
    input  logic             rst,
    rd_adr_sequencer_if.master bus
);
    localparam int CH_W   = ch_width(N_CH);
    localparam int SLOT_W = $clog2(SLOT_LEN);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_LEN - 1);
    localparam logic [ADR_W-1:0]  WORD_LAST = ADR_W'(N_WORDS - 1);

    generate
        if (RD_OFF > SLOT_LEN || RD_ON >= RD_OFF || RD_ON < 0 || SLOT_LEN < 4 ||
            N_WORDS < 1 || N_WORDS > (1 << ADR_W) || N_CH < 1 || N_CH > 16)
        begin : g_param_check
            $error("rd_adr_sequencer: illegal parameter combination");
        end
    endgenerate

    // ---------------- strobe capture ----------------
    logic [N_CH-1:0] strob_s1, strob_s2, strob_s3;
    logic [N_CH-1:0] edge_r;
    logic [N_CH-1:0] pending, pending_n;
    logic [N_CH-1:0] overrun_r;
    logic [N_CH-1:0] grant_mask, clr_mask;

    // ---------------- burst FSM ----------------
    seq_state_t        state, state_n;
    logic [SLOT_W-1:0] slot_cnt, slot_n;
    logic [ADR_W-1:0]  word_cnt, word_n;
    logic [CH_W-1:0]   ch_idx_r, ch_n;
    logic [CH_W-1:0]   rr_ptr, rr_n;
    logic [N_CH-1:0]   rd_r, rd_n;
    logic [CH_W-1:0]   win;
    logic              win_any;

    rd_seq_arbiter #(
        .N_CH   (N_CH),
        .ARB_RR (ARB_RR)
    ) u_arb (
        .pending (pending),
        .ptr     (rr_ptr),
        .grant   (win),
        .any     (win_any)
    );

    assign grant_mask = (state != ST_IDLE) ? (N_CH'(1) << ch_idx_r) : '0;
    assign clr_mask   = (state == ST_IDLE && win_any) ? (N_CH'(1) << win) : '0;

    // An edge only latches when the channel is neither pending nor being
    // served; otherwise it is reported as dropped.
    assign pending_n = (pending & ~clr_mask) | (edge_r & ~pending & ~grant_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            strob_s1  <= '0;
            strob_s2  <= '0;
            strob_s3  <= '0;
            edge_r    <= '0;
            pending   <= '0;
            overrun_r <= '0;
        end else begin
            strob_s1  <= bus.strob;
            strob_s2  <= strob_s1;
            strob_s3  <= strob_s2;
            edge_r    <= strob_s2 & ~strob_s3;
            pending   <= pending_n;
            overrun_r <= edge_r & (pending | grant_mask);
        end
    end

    always_comb begin
        state_n = state;
        slot_n  = slot_cnt;
        word_n  = word_cnt;
        ch_n    = ch_idx_r;
        rr_n    = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (win_any) begin
                    state_n = ST_SLOT;
                    ch_n    = win;
                    slot_n  = '0;
                    word_n  = '0;
                end
            end
            ST_SLOT: begin
                if (slot_cnt == SLOT_LAST) begin
                    if (word_cnt == WORD_LAST) begin
                        state_n = ST_DONE;
                    end else begin
                        word_n = word_cnt + 1'b1;
                        slot_n = '0;
                    end
                end else begin
                    slot_n = slot_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                slot_n  = '0;
                word_n  = '0;
                if (ARB_RR != 0) begin
                    rr_n = (int'(ch_idx_r) == N_CH - 1) ? '0 : ch_idx_r + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // rd is registered from the next-state values so it lines up exactly
    // with the slot_cnt value it decodes.
    assign rd_n = (state_n == ST_SLOT && int'(slot_n) >= RD_ON && int'(slot_n) < RD_OFF)
                  ? (N_CH'(1) << ch_n) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
            word_cnt <= '0;
            ch_idx_r <= '0;
            rr_ptr   <= '0;
            rd_r     <= '0;
        end else begin
            state    <= state_n;
            slot_cnt <= slot_n;
            word_cnt <= word_n;
            ch_idx_r <= ch_n;
            rr_ptr   <= rr_n;
            rd_r     <= rd_n;
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.adr_valid = (state != ST_IDLE);
    assign bus.rd_adr    = (state != ST_IDLE) ? word_cnt : '0;
    assign bus.ch_idx    = ch_idx_r;
    assign bus.rd        = rd_r;
    assign bus.done      = (state == ST_DONE) ? grant_mask : '0;
    assign bus.overrun   = overrun_r;

endmodule
`default_nettype wire

// File: tb/tb_rd_adr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rd_adr_sequencer
//  Purpose  : Directed bench for rd_adr_sequencer. Three instances:
//             fixed-priority defaults, round-robin defaults, and a small
//             2-channel / 4-word / 8-cycle-slot build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rd_adr_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rd_adr_sequencer_if #(.N_CH(5), .ADR_W(5)) fif ();
    rd_adr_sequencer_if #(.N_CH(5), .ADR_W(5)) rif ();
    rd_adr_sequencer_if #(.N_CH(2), .ADR_W(5)) sif ();

    rd_adr_sequencer #(.ARB_RR(0)) dut_fp (.clk(clk), .rst(rst), .bus(fif));
    rd_adr_sequencer #(.ARB_RR(1)) dut_rr (.clk(clk), .rst(rst), .bus(rif));
    rd_adr_sequencer #(.N_CH(2), .N_WORDS(4), .ADR_W(5), .SLOT_LEN(8),
                       .RD_ON(2), .RD_OFF(7), .ARB_RR(0))
                     dut_sm (.clk(clk), .rst(rst), .bus(sif));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fif.strob = '0;
        rif.strob = '0;
        sif.strob = '0;
        repeat (3) tick();
        total++; if (fif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", fif.busy); end
        total++; if (fif.adr_valid !== 1'b0) begin bad++; $display("FAIL reset_adr_valid got=%b want=0", fif.adr_valid); end
        total++; if (fif.rd !== 5'b0) begin bad++; $display("FAIL reset_rd got=%b want=00000", fif.rd); end
        total++; if (fif.rd_adr !== 5'd0) begin bad++; $display("FAIL reset_rd_adr got=%0d want=0", fif.rd_adr); end
        total++; if (fif.done !== 5'b0) begin bad++; $display("FAIL reset_done got=%b want=00000", fif.done); end
        total++; if (fif.overrun !== 5'b0) begin bad++; $display("FAIL reset_overrun got=%b want=00000", fif.overrun); end
        total++; if (fif.ch_idx !== 3'd0) begin bad++; $display("FAIL reset_ch_idx got=%0d want=0", fif.ch_idx); end
        total++; if ({rif.busy, rif.rd} !== 6'b0) begin bad++; $display("FAIL reset_rr got=%b want=000000", {rif.busy, rif.rd}); end
        total++; if ({sif.busy, sif.rd} !== 3'b0) begin bad++; $display("FAIL reset_small got=%b want=000", {sif.busy, sif.rd}); end
        rst = 1'b0;
        tick();
    endtask

    // Strobe set in cycle 0 is first sampled at edge 1; grant lands after edge 5.
    task automatic test_single();
        int rises, hi, w, off;
        logic prev;
        logic       e_busy;
        logic [4:0] e_rd, e_done, e_adr;
        rises = 0; hi = 0; prev = 1'b0;
        fif.strob = 5'b00001;
        for (int t = 1; t <= 1170; t++) begin
            tick();
            if (t == 3) fif.strob = '0;
            e_busy = (t >= 5 && t <= 1157);
            w = (t - 5) / 64;
            if (w > 17) w = 17;
            e_adr = e_busy ? 5'(w) : 5'd0;
            off = (t - 5) % 64;
            e_rd = (t >= 5 && t < 1157 && off >= 40 && off < 44) ? 5'b00001 : 5'b0;
            e_done = (t == 1157) ? 5'b00001 : 5'b0;
            total++;
            if ({fif.busy, fif.adr_valid, fif.rd, fif.rd_adr, fif.done, fif.overrun} !==
                {e_busy, e_busy, e_rd, e_adr, e_done, 5'b0}) begin
                bad++;
                $display("FAIL single_cyc t=%0d busy=%b/%b rd=%b/%b adr=%0d/%0d done=%b/%b ovr=%b/00000",
                         t, fif.busy, e_busy, fif.rd, e_rd, fif.rd_adr, e_adr, fif.done, e_done, fif.overrun);
            end
            if (fif.rd[0] && !prev) rises++;
            if (fif.rd[0]) hi++;
            prev = fif.rd[0];
        end
        total++; if (rises != 18) begin bad++; $display("FAIL single_rd_pulses got=%0d want=18", rises); end
        total++; if (hi != 72) begin bad++; $display("FAIL single_rd_cycles got=%0d want=72", hi); end
    endtask

    task automatic test_fixed_priority();
        int g_t[4], d_t[4];
        int g_ch[4];
        logic [4:0] d_v[4];
        int ng, nd, ov;
        logic prev;
        ng = 0; nd = 0; ov = 0; prev = 1'b0;
        for (int k = 0; k < 4; k++) begin g_t[k] = -1; d_t[k] = -1; g_ch[k] = -1; d_v[k] = 'x; end
        fif.strob = 5'b01010;
        for (int t = 1; t <= 2330; t++) begin
            tick();
            if (t == 3) fif.strob = '0;
            if (fif.busy && !prev) begin
                if (ng < 4) begin g_t[ng] = t; g_ch[ng] = int'(fif.ch_idx); end
                ng++;
            end
            prev = fif.busy;
            if (fif.done != 5'b0) begin
                if (nd < 4) begin d_t[nd] = t; d_v[nd] = fif.done; end
                nd++;
            end
            if (fif.overrun != 5'b0) ov++;
        end
        total++; if (ng != 2) begin bad++; $display("FAIL fp_grants got=%0d want=2", ng); end
        total++; if (g_t[0] != 5 || g_ch[0] != 1) begin bad++; $display("FAIL fp_first got=t%0d/ch%0d want=t5/ch1", g_t[0], g_ch[0]); end
        total++; if (g_t[1] != 1159 || g_ch[1] != 3) begin bad++; $display("FAIL fp_second got=t%0d/ch%0d want=t1159/ch3", g_t[1], g_ch[1]); end
        total++; if (nd != 2) begin bad++; $display("FAIL fp_done_count got=%0d want=2", nd); end
        total++; if (d_t[0] != 1157 || d_v[0] !== 5'b00010) begin bad++; $display("FAIL fp_done1 got=t%0d/%b want=t1157/00010", d_t[0], d_v[0]); end
        total++; if (d_t[1] != 2311 || d_v[1] !== 5'b01000) begin bad++; $display("FAIL fp_done3 got=t%0d/%b want=t2311/01000", d_t[1], d_v[1]); end
        total++; if (ov != 0) begin bad++; $display("FAIL fp_overrun got=%0d want=0", ov); end
    endtask

    // Rounds 0/1: all five together (pointer must wrap 4->0 between rounds).
    // Rounds 2/3: ch0 alone moves the pointer to 1, then {0,2} must serve 2 first.
    task automatic test_round_robin();
        logic [4:0] masks[4];
        int n_exp[4];
        int ord[4][5];
        int got_ch[5], got_t[5];
        int nd, ch;
        masks = '{5'b11111, 5'b11111, 5'b00001, 5'b00101};
        n_exp = '{5, 5, 1, 2};
        ord   = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 3, 4}, '{0, 0, 0, 0, 0}, '{2, 0, 0, 0, 0}};
        for (int p = 0; p < 4; p++) begin
            nd = 0;
            for (int k = 0; k < 5; k++) begin got_ch[k] = -1; got_t[k] = -1; end
            rif.strob = masks[p];
            for (int t = 1; t <= n_exp[p] * 1154 + 10; t++) begin
                tick();
                if (t == 3) rif.strob = '0;
                if (rif.done != 5'b0) begin
                    ch = -1;
                    for (int i = 0; i < 5; i++) if (rif.done[i]) ch = (ch == -1) ? i : 99;
                    if (nd < 5) begin got_ch[nd] = ch; got_t[nd] = t; end
                    nd++;
                end
            end
            total++; if (nd != n_exp[p]) begin bad++; $display("FAIL rr_count round=%0d got=%0d want=%0d", p, nd, n_exp[p]); end
            for (int k = 0; k < n_exp[p]; k++) begin
                total++;
                if (got_ch[k] != ord[p][k] || got_t[k] != 1157 + k * 1154) begin
                    bad++;
                    $display("FAIL rr_order round=%0d slot=%0d got=ch%0d/t%0d want=ch%0d/t%0d",
                             p, k, got_ch[k], got_t[k], ord[p][k], 1157 + k * 1154);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int ov2, ov_other, d1, d2, ng, g2_t, g2_ch;
        logic prev;
        ov2 = 0; ov_other = 0; d1 = 0; d2 = 0; ng = 0; g2_t = -1; g2_ch = -1; prev = 1'b0;
        fif.strob = 5'b00010;
        for (int t = 1; t <= 2330; t++) begin
            tick();
            fif.strob[1] = (t < 3);
            fif.strob[2] = (t >= 50 && t < 53) || (t >= 100 && t < 103) || (t >= 1300 && t < 1303);
            if (fif.busy && !prev) begin
                ng++;
                if (ng == 2) begin g2_t = t; g2_ch = int'(fif.ch_idx); end
            end
            prev = fif.busy;
            if (fif.overrun[2]) ov2++;
            if ((fif.overrun & 5'b11011) != 5'b0) ov_other++;
            if (fif.done[1]) d1++;
            if (fif.done[2]) d2++;
        end
        total++; if (ov2 != 2) begin bad++; $display("FAIL ovr_ch2 got=%0d want=2", ov2); end
        total++; if (ov_other != 0) begin bad++; $display("FAIL ovr_other got=%0d want=0", ov_other); end
        total++; if (ng != 2) begin bad++; $display("FAIL ovr_grants got=%0d want=2", ng); end
        total++; if (g2_t != 1159 || g2_ch != 2) begin bad++; $display("FAIL ovr_grant2 got=t%0d/ch%0d want=t1159/ch2", g2_t, g2_ch); end
        total++; if (d1 != 1 || d2 != 1) begin bad++; $display("FAIL ovr_done got=%0d/%0d want=1/1", d1, d2); end
    endtask

    task automatic test_reset_mid_burst();
        int dn, g_t, g_ch, d_t;
        logic [4:0] d_v;
        logic prev;
        dn = 0;
        fif.strob = 5'b00001;
        for (int t = 1; t <= 494; t++) begin
            tick();
            fif.strob[0] = (t < 3);
            fif.strob[3] = (t >= 300 && t < 303);
            if (fif.done != 5'b0) dn++;
        end
        // word 7, slot 41
        total++; if (fif.rd !== 5'b00001) begin bad++; $display("FAIL rst_pre_rd got=%b want=00001", fif.rd); end
        total++; if (fif.rd_adr !== 5'd7) begin bad++; $display("FAIL rst_pre_adr got=%0d want=7", fif.rd_adr); end
        rst = 1'b1;
        tick();
        total++; if (fif.rd !== 5'b0) begin bad++; $display("FAIL rst_rd got=%b want=00000", fif.rd); end
        total++; if (fif.busy !== 1'b0 || fif.adr_valid !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b%b want=00", fif.busy, fif.adr_valid); end
        total++; if (fif.rd_adr !== 5'd0) begin bad++; $display("FAIL rst_adr got=%0d want=0", fif.rd_adr); end
        rst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (fif.done != 5'b0) dn++;
            total++;
            if (fif.busy !== 1'b0) begin bad++; $display("FAIL rst_idle t=%0d busy=%b want=0", t, fif.busy); end
            tick();
        end
        total++; if (dn != 0) begin bad++; $display("FAIL rst_no_done got=%0d want=0", dn); end
        g_t = -1; g_ch = -1; d_t = -1; d_v = '0; prev = 1'b0;
        fif.strob = 5'b10000;
        for (int t = 1; t <= 1165; t++) begin
            tick();
            if (t == 3) fif.strob = '0;
            if (fif.busy && !prev && g_t < 0) begin g_t = t; g_ch = int'(fif.ch_idx); end
            prev = fif.busy;
            if (fif.done != 5'b0 && d_t < 0) begin d_t = t; d_v = fif.done; end
        end
        total++; if (g_t != 5 || g_ch != 4) begin bad++; $display("FAIL rst_regrant got=t%0d/ch%0d want=t5/ch4", g_t, g_ch); end
        total++; if (d_t != 1157 || d_v !== 5'b10000) begin bad++; $display("FAIL rst_redone got=t%0d/%b want=t1157/10000", d_t, d_v); end
    endtask

    task automatic test_small_config();
        int rises, hi, bz, w, off;
        logic prev;
        logic       e_busy;
        logic [1:0] e_rd, e_done;
        logic [4:0] e_adr;
        rises = 0; hi = 0; bz = 0; prev = 1'b0;
        sif.strob = 2'b10;
        for (int t = 1; t <= 45; t++) begin
            tick();
            if (t == 3) sif.strob = '0;
            e_busy = (t >= 5 && t <= 37);
            w = (t - 5) / 8;
            if (w > 3) w = 3;
            e_adr = e_busy ? 5'(w) : 5'd0;
            off = (t - 5) % 8;
            e_rd = (t >= 5 && t < 37 && off >= 2 && off < 7) ? 2'b10 : 2'b00;
            e_done = (t == 37) ? 2'b10 : 2'b00;
            total++;
            if ({sif.busy, sif.rd, sif.rd_adr, sif.done} !== {e_busy, e_rd, e_adr, e_done}) begin
                bad++;
                $display("FAIL small_cyc t=%0d busy=%b/%b rd=%b/%b adr=%0d/%0d done=%b/%b",
                         t, sif.busy, e_busy, sif.rd, e_rd, sif.rd_adr, e_adr, sif.done, e_done);
            end
            if (t == 5) begin
                total++;
                if (sif.ch_idx !== 1'b1) begin bad++; $display("FAIL small_ch got=%0d want=1", sif.ch_idx); end
            end
            if (sif.rd[1] && !prev) rises++;
            if (sif.rd[1]) hi++;
            if (sif.busy) bz++;
            prev = sif.rd[1];
        end
        total++; if (rises != 4) begin bad++; $display("FAIL small_pulses got=%0d want=4", rises); end
        total++; if (hi != 20) begin bad++; $display("FAIL small_rd_cycles got=%0d want=20", hi); end
        total++; if (bz != 33) begin bad++; $display("FAIL small_burst_len got=%0d want=33", bz); end
    endtask

    initial begin
        test_reset();
        test_single();
        tick();
        test_fixed_priority();
        tick();
        test_round_robin();
        tick();
        test_overrun();
        tick();
        test_reset_mid_burst();
        tick();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
